// File: rtl/level_history_scroller.sv
// Scrolling bar-graph history of the water level for the 8x8 bicolour matrix.
// Each shift moves the image one column left and enters a bar for the latched
// level at column 7; bars at or above ALARM_LEVEL go to the red frame.
module level_history_scroller #(
  parameter int SHIFT_DIV   = 1000,
  parameter int ALARM_LEVEL = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        level_valid,
  input  logic [3:0]  level,
  input  logic        freeze,
  input  logic        clear,
  output logic [63:0] PICTURE_R,
  output logic [63:0] PICTURE_G,
  output logic        shift_pulse,
  output logic        alarm
);

  localparam int               DIV_W    = $clog2(SHIFT_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);

  logic [63:0]      pic_r_q, pic_r_d;
  logic [63:0]      pic_g_q, pic_g_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       lvl_q, lvl_d;
  logic             pulse_q, pulse_d;
  logic             alarm_q, alarm_d;
  logic [7:0]       bar;

  // Samples above full scale are shown as a full column.
  function automatic logic [3:0] clamp_level(input logic [3:0] l);
    return (l > 4'd8) ? 4'd8 : l;
  endfunction

  function automatic logic is_alarm(input logic [3:0] l);
    return (int'(l) >= ALARM_LEVEL);
  endfunction

  // Bit r set when row r is lit: rows 7 down to 8-L, growing from the bottom.
  function automatic logic [7:0] bar_rows(input logic [3:0] l);
    logic [7:0] rows;
    for (int r = 0; r < 8; r++) begin
      rows[r] = ((r + int'(l)) >= 8);
    end
    return rows;
  endfunction

  // Column c takes column c+1 in every row; col7 bit r becomes the new column 7 of row r.
  function automatic logic [63:0] scroll(input logic [63:0] frame, input logic [7:0] col7);
    logic [63:0] f;
    for (int r = 0; r < 8; r++) begin
      f[8*r +: 8] = {col7[r], frame[8*r+1 +: 7]};
    end
    return f;
  endfunction

  // Next state: level latch, divider, and the shift/clear frame update.
  always_comb begin
    lvl_d   = level_valid ? clamp_level(level) : lvl_q;
    alarm_d = is_alarm(lvl_d);
    pic_r_d = pic_r_q;
    pic_g_d = pic_g_q;
    div_d   = div_q;
    pulse_d = 1'b0;
    bar     = bar_rows(lvl_q);
    if (clear) begin
      pic_r_d = '0;
      pic_g_d = '0;
      div_d   = '0;
    end else if (!freeze) begin
      if (div_q == DIV_LAST) begin
        // The bar uses the value latched before this edge, even if a strobe arrives now.
        div_d   = '0;
        pulse_d = 1'b1;
        pic_r_d = scroll(pic_r_q, is_alarm(lvl_q) ? bar : 8'h00);
        pic_g_d = scroll(pic_g_q, is_alarm(lvl_q) ? 8'h00 : bar);
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // State registers with immediate asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pic_r_q <= '0;
      pic_g_q <= '0;
      div_q   <= '0;
      lvl_q   <= '0;
      pulse_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      pic_r_q <= pic_r_d;
      pic_g_q <= pic_g_d;
      div_q   <= div_d;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      alarm_q <= alarm_d;
    end
  end

  assign PICTURE_R   = pic_r_q;
  assign PICTURE_G   = pic_g_q;
  assign shift_pulse = pulse_q;
  assign alarm       = alarm_q;

endmodule

// File: tb/tb_level_history_scroller.sv
// Bench for level_history_scroller: directed scenarios with literal frames,
// a randomized phase, and a column-history model checked every cycle.
module tb_level_history_scroller;

  localparam int SHIFT_DIV   = 4;
  localparam int ALARM_LEVEL = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        level_valid = 1'b0;
  logic [3:0]  level = 4'd0;
  logic        freeze = 1'b0;
  logic        clear = 1'b0;
  logic [63:0] PICTURE_R, PICTURE_G;
  logic        shift_pulse, alarm;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: level and colour of each displayed column, plus latch and divider.
  int m_lvl[8];
  bit m_red[8];
  int m_latch = 0;
  bit m_alarm = 1'b0;
  int m_div = 0;
  bit m_pulse = 1'b0;

  level_history_scroller #(.SHIFT_DIV(SHIFT_DIV), .ALARM_LEVEL(ALARM_LEVEL)) dut (
    .clk(clk), .rst(rst), .level_valid(level_valid), .level(level),
    .freeze(freeze), .clear(clear), .PICTURE_R(PICTURE_R), .PICTURE_G(PICTURE_G),
    .shift_pulse(shift_pulse), .alarm(alarm)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_frame(input bit want_red);
    logic [63:0] f;
    f = '0;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++)
        if (m_red[c] == want_red && r >= 8 - m_lvl[c]) f[8*r + c] = 1'b1;
    return f;
  endfunction

  // Reference model, advanced on every rising clock and on reset assertion.
  initial begin
    for (int c = 0; c < 8; c++) begin m_lvl[c] = 0; m_red[c] = 0; end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int c = 0; c < 8; c++) begin m_lvl[c] = 0; m_red[c] = 0; end
        m_latch = 0; m_alarm = 0; m_div = 0; m_pulse = 0;
      end else begin
        int nl;
        nl = level_valid ? ((int'(level) > 8) ? 8 : int'(level)) : m_latch;
        m_pulse = 0;
        if (clear) begin
          for (int c = 0; c < 8; c++) begin m_lvl[c] = 0; m_red[c] = 0; end
          m_div = 0;
        end else if (!freeze) begin
          if (m_div == SHIFT_DIV - 1) begin
            for (int c = 0; c < 7; c++) begin m_lvl[c] = m_lvl[c+1]; m_red[c] = m_red[c+1]; end
            m_lvl[7] = m_latch;
            m_red[7] = (m_latch >= ALARM_LEVEL);
            m_div = 0;
            m_pulse = 1;
          end else begin
            m_div++;
          end
        end
        m_latch = nl;
        m_alarm = (m_latch >= ALARM_LEVEL);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_R", PICTURE_R, model_frame(1'b1));
      chk("model_G", PICTURE_G, model_frame(1'b0));
      chk("model_pulse", {63'd0, shift_pulse}, {63'd0, m_pulse});
      chk("model_alarm", {63'd0, alarm}, {63'd0, m_alarm});
    end
  end

  task automatic cycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] l);
    level = l;
    level_valid = 1'b1;
    cycle(1);
    level_valid = 1'b0;
  endtask

  task automatic wait_pulse(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (shift_pulse === 1'b1) begin got = 1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no shift_pulse within 20 cycles (got 0, expected 1)", name);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    cycle(2);
    chk("rst_R", PICTURE_R, 64'd0);
    chk("rst_G", PICTURE_G, 64'd0);
    chk("rst_pulse", {63'd0, shift_pulse}, 64'd0);
    chk("rst_alarm", {63'd0, alarm}, 64'd0);
    rst = 1'b0;

    // First shift on the 4th edge after release, frames stay blank.
    cycle(3);
    chk("first_pulse_early", {63'd0, shift_pulse}, 64'd0);
    cycle(1);
    chk("first_pulse", {63'd0, shift_pulse}, 64'd1);
    chk("first_R", PICTURE_R, 64'd0);
    chk("first_G", PICTURE_G, 64'd0);

    // Green bar of level 3.
    strobe(4'd3);
    wait_pulse("wait_green");
    chk("green_G", PICTURE_G, 64'h8080_8000_0000_0000);
    chk("green_R", PICTURE_R, 64'd0);
    chk("green_alarm", {63'd0, alarm}, 64'd0);

    // Red full bar, previous bar scrolls to column 6.
    strobe(4'd8);
    wait_pulse("wait_red");
    chk("red_R", PICTURE_R, 64'h8080_8080_8080_8080);
    chk("red_G", PICTURE_G, 64'h4040_4000_0000_0000);
    chk("red_alarm", {63'd0, alarm}, 64'd1);

    // Clamp: 12 displays as 8.
    strobe(4'd12);
    wait_pulse("wait_clamp");
    chk("clamp_R", PICTURE_R, 64'hC0C0_C0C0_C0C0_C0C0);
    chk("clamp_G", PICTURE_G, 64'h2020_2000_0000_0000);

    // Strobe of 2 on the shift edge: this shift still uses 8.
    cycle(SHIFT_DIV - 1);
    level = 4'd2;
    level_valid = 1'b1;
    cycle(1);
    level_valid = 1'b0;
    chk("same_edge_pulse", {63'd0, shift_pulse}, 64'd1);
    chk("same_edge_R", PICTURE_R, 64'hE0E0_E0E0_E0E0_E0E0);
    chk("same_edge_G", PICTURE_G, 64'h1010_1000_0000_0000);
    chk("same_edge_alarm", {63'd0, alarm}, 64'd0);
    wait_pulse("wait_level2");
    chk("level2_R", PICTURE_R, 64'h7070_7070_7070_7070);
    chk("level2_G", PICTURE_G, 64'h8888_0800_0000_0000);

    // Scroll everything out with level 0.
    strobe(4'd0);
    for (int i = 0; i < 8; i++) wait_pulse("wait_scroll");
    chk("scroll_R", PICTURE_R, 64'd0);
    chk("scroll_G", PICTURE_G, 64'd0);
    chk("scroll_alarm", {63'd0, alarm}, 64'd0);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) freeze = ~freeze;
      clear = ($urandom_range(0, 99) == 0);
      level_valid = !clear && ($urandom_range(0, 2) == 0);
      level = 4'($urandom_range(0, 15));
      cycle(1);
    end
    freeze = 1'b0;
    level_valid = 1'b0;

    // Known state, then freeze.
    clear = 1'b1;
    cycle(1);
    clear = 1'b0;
    chk("clr0_R", PICTURE_R, 64'd0);
    chk("clr0_G", PICTURE_G, 64'd0);
    chk("clr0_pulse", {63'd0, shift_pulse}, 64'd0);
    strobe(4'd7);
    wait_pulse("wait_seven_a");
    wait_pulse("wait_seven_b");
    chk("seven_R", PICTURE_R, 64'hC0C0_C0C0_C0C0_C000);
    chk("seven_G", PICTURE_G, 64'd0);
    freeze = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(1);
      chk("freeze_pulse", {63'd0, shift_pulse}, 64'd0);
    end
    chk("freeze_R", PICTURE_R, 64'hC0C0_C0C0_C0C0_C000);
    chk("freeze_alarm", {63'd0, alarm}, 64'd1);

    // Clear has priority over freeze; latch and alarm survive.
    clear = 1'b1;
    cycle(1);
    clear = 1'b0;
    freeze = 1'b0;
    chk("clear_R", PICTURE_R, 64'd0);
    chk("clear_G", PICTURE_G, 64'd0);
    chk("clear_alarm", {63'd0, alarm}, 64'd1);
    wait_pulse("wait_after_clear");
    chk("after_clear_R", PICTURE_R, 64'h8080_8080_8080_8000);

    // Async reset mid-cycle, checked before any clock edge.
    cycle(1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_R", PICTURE_R, 64'd0);
    chk("async_G", PICTURE_G, 64'd0);
    chk("async_pulse", {63'd0, shift_pulse}, 64'd0);
    chk("async_alarm", {63'd0, alarm}, 64'd0);
    cycle(2);
    rst = 1'b0;
    cycle(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
